reg_16bit_arbiter: RTL



---
 rtl/reg_16bit_arbiter_pkg.sv | 16 +
 rtl/reg_16bit_arbiter_rr_pick.sv | 28 ++
 rtl/reg_16bit_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/reg_16bit_arbiter_pkg.sv
// Shared opcode and FSM state definitions for the reg_16bit command arbiter.
// Imported by the top level and by any later arbiters that reuse rr_pick.
package reg_arb_pkg;

   localparam logic [1:0] OP_CLR   = 2'b00;
   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_INCR  = 2'b10;
   localparam logic [1:0] OP_BURST = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_ACK   = 2'd2
   } state_t;

endpackage

// File: rtl/reg_16bit_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i wins.
// NREQ must be a power of two so the index addition wraps on its own.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IW-1:0]   ptr_i,
   output logic [IW-1:0]   winner_o,
   output logic            valid_o
);

   logic [IW-1:0] idx;

   always_comb begin
      winner_o = '0;
      valid_o  = 1'b0;
      idx      = '0;
      for (int i = 0; i < NREQ; i++) begin
         idx = ptr_i + IW'(i);
         if (!valid_o && req_i[idx]) begin
            winner_o = idx;
            valid_o  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/reg_16bit_arbiter.sv
// Round-robin arbiter that turns one granted command into registered
// clr/load/incr strobes for a shared reg_16bit, then acks the requester.
module reg_16bit_arbiter
   import reg_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int DW   = 16,
   parameter int CW   = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_i,
   input  logic [2*NREQ-1:0]        req_op_i,
   input  logic [DW*NREQ-1:0]       req_data_i,
   output logic [NREQ-1:0]          ack_o,
   output logic                     busy_o,
   output logic [$clog2(NREQ)-1:0]  owner_o,
   output logic                     reg_clr_o,
   output logic                     reg_load_o,
   output logic                     reg_incr_o,
   output logic [DW-1:0]            reg_load_input_o,
   output logic [1:0]               dbg_state_o
);

   localparam int IW = $clog2(NREQ);

   state_t          state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [IW-1:0]   owner_q, owner_d;
   logic [1:0]      op_q, op_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [NREQ-1:0] ack_q, ack_d;
   logic            busy_q, busy_d;
   logic            clr_q, clr_d;
   logic            load_q, load_d;
   logic            incr_q, incr_d;
   logic [DW-1:0]   li_q, li_d;

   logic [IW-1:0]   win;
   logic            win_valid;
   logic [1:0]      win_op;
   logic [DW-1:0]   win_data;

   rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
      .req_i    (req_i),
      .ptr_i    (ptr_q),
      .winner_o (win),
      .valid_o  (win_valid)
   );

   assign win_op   = req_op_i[2*int'(win) +: 2];
   assign win_data = req_data_i[DW*int'(win) +: DW];

   // Outputs are computed one cycle ahead so every strobe leaves a flop.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      ack_d   = '0;
      busy_d  = 1'b0;
      clr_d   = 1'b0;
      load_d  = 1'b0;
      incr_d  = 1'b0;
      li_d    = '0;
      case (state_q)
         S_IDLE: begin
            if (win_valid) begin
               owner_d = win;
               op_d    = win_op;
               busy_d  = 1'b1;
               state_d = S_ISSUE;
               case (win_op)
                  OP_CLR:  clr_d = 1'b1;
                  OP_LOAD: begin
                     load_d = 1'b1;
                     li_d   = win_data;
                  end
                  OP_INCR: incr_d = 1'b1;
                  default: begin
                     if (win_data[CW-1:0] == '0) begin
                        state_d    = S_ACK;
                        ack_d[win] = 1'b1;
                     end else begin
                        incr_d = 1'b1;
                        cnt_d  = win_data[CW-1:0] - CW'(1);
                     end
                  end
               endcase
            end
         end
         S_ISSUE: begin
            busy_d = 1'b1;
            // cnt_q counts the increments still owed after the current one
            if (op_q == OP_BURST && cnt_q != '0) begin
               incr_d = 1'b1;
               cnt_d  = cnt_q - CW'(1);
            end else begin
               state_d        = S_ACK;
               ack_d[owner_q] = 1'b1;
            end
         end
         S_ACK: begin
            state_d = S_IDLE;
            ptr_d   = owner_q + IW'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         op_q    <= OP_CLR;
         cnt_q   <= '0;
         ack_q   <= '0;
         busy_q  <= 1'b0;
         clr_q   <= 1'b0;
         load_q  <= 1'b0;
         incr_q  <= 1'b0;
         li_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
         clr_q   <= clr_d;
         load_q  <= load_d;
         incr_q  <= incr_d;
         li_q    <= li_d;
      end
   end

   assign ack_o            = ack_q;
   assign busy_o           = busy_q;
   assign owner_o          = owner_q;
   assign reg_clr_o        = clr_q;
   assign reg_load_o       = load_q;
   assign reg_incr_o       = incr_q;
   assign reg_load_input_o = li_q;
   assign dbg_state_o      = state_q;

endmodule
